// File: rtl/ext_irq_pkg.sv
// Shared constants for the external interrupt controller: source count,
// register map and handshake FSM states.
package ext_irq_pkg;
  localparam int NUM_SRC = 31;
  localparam int ID_W    = 5;

  localparam logic [1:0] EIRQ_ENABLE = 2'd0;
  localparam logic [1:0] EIRQ_EDGE   = 2'd1;
  localparam logic [1:0] EIRQ_PEND   = 2'd2;
  localparam logic [1:0] EIRQ_STAT   = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_e;
endpackage

// File: rtl/irq_sync_edge.sv
// Per-source 2-FF synchroniser plus a third stage for rising-edge detection.
module irq_sync_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);
  logic s1_reg, s2_reg, s3_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= async_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign sync_out = s2_reg;
  assign rise     = s2_reg & ~s3_reg;
endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronise, latch pending, mask, pick the
// lowest-index eligible source and present it to the core with req/ack.
module ext_irq_ctrl
  import ext_irq_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NUM_SRC-1:0] i_ext,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [NUM_SRC-1:0] cfg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack
);
  logic [NUM_SRC-1:0] s2, rise;
  logic [NUM_SRC-1:0] enable_reg, edge_sel_reg, pend_reg, pend_next;
  logic [NUM_SRC-1:0] eligible, w1c, ack_clr;
  logic [ID_W-1:0]    winner;
  logic               ack_fire;
  irq_state_e         state_reg;

  assign ack_fire = (state_reg == REQ) && irq_ack;
  assign w1c      = (cfg_we && cfg_addr == EIRQ_PEND) ? cfg_wdata : '0;
  assign eligible = pend_reg & enable_reg;

  // A fresh edge always wins over ack-clear and W1C on the same bit.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      irq_sync_edge u_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .async_in (i_ext[gi]),
        .sync_out (s2[gi]),
        .rise     (rise[gi])
      );
      assign ack_clr[gi]   = ack_fire && (irq_id == ID_W'(gi));
      assign pend_next[gi] = edge_sel_reg[gi]
                           ? (rise[gi] | (pend_reg[gi] & ~w1c[gi] & ~ack_clr[gi]))
                           : s2[gi];
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      EIRQ_ENABLE: cfg_rdata = enable_reg;
      EIRQ_EDGE:   cfg_rdata = edge_sel_reg;
      EIRQ_PEND:   cfg_rdata = pend_reg;
      EIRQ_STAT:   cfg_rdata = NUM_SRC'({irq_req, irq_id});
      default:     cfg_rdata = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      enable_reg   <= '0;
      edge_sel_reg <= '0;
      pend_reg     <= '0;
    end else begin
      pend_reg <= pend_next;
      if (cfg_we && cfg_addr == EIRQ_ENABLE) enable_reg   <= cfg_wdata;
      if (cfg_we && cfg_addr == EIRQ_EDGE)   edge_sel_reg <= cfg_wdata;
    end
  end

  // GAP forces one low cycle after an ack; from there a new grant is taken
  // straight away so back-to-back requests see exactly one idle cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= IDLE;
      irq_req   <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state_reg)
        REQ: begin
          if (irq_ack) begin
            state_reg <= GAP;
            irq_req   <= 1'b0;
          end else if (!eligible[irq_id]) begin
            state_reg <= IDLE;
            irq_req   <= 1'b0;
          end
        end
        default: begin
          if (|eligible) begin
            state_reg <= REQ;
            irq_req   <= 1'b1;
            irq_id    <= winner;
          end else begin
            state_reg <= IDLE;
            irq_req   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
